uart_tx_frame: RTL

Serializing transmit stage of the UART link. It accepts one byte per handshake and drives serial_data_out with one frame per byte.
- Frame order: start(0), parity, data[0]..data[7], STOP_BITS stop bits(1).
- Parity is odd: parity = ~^data.
- The frame is bit-compatible with the receiver's 9-bit right-shift capture and its odd-parity check.
- Contains its own bit-period counter, so no external baud clock is needed.

---
 rtl/uart_tx_frame_pkg.sv | 23 ++
 rtl/uart_tx_frame_piso_reg.sv | 29 ++
 rtl/uart_tx_frame.sv | 137 +++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_pkg.sv
// Shared UART definitions: frame state encoding, widths, default timing
// and the odd-parity helper used by both transmit and receive paths.
package uart_tx_frame_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 434;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_PARITY,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(
    input logic [DATA_BITS-1:0] d
  );
    return ~^d;
  endfunction

endpackage

// File: rtl/uart_tx_frame_piso_reg.sv
// Parallel-in serial-out byte register; LSB is presented first.
// Transmit counterpart of the receiver's capture shift register.
module piso_reg
  import uart_tx_frame_pkg::*;
(
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 shift,
  input  logic [DATA_BITS-1:0] d,
  output logic                 lsb
);

  logic [DATA_BITS-1:0] data_q;

  // Load wins over shift; shifting moves the next bit into the LSB.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= d;
    end else if (shift) begin
      data_q <= {1'b0, data_q[DATA_BITS-1:1]};
    end
  end

  assign lsb = data_q[0];

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, odd parity, 8 data bits LSB first,
// then STOP_BITS stop bits, each held CLKS_PER_BIT clocks.
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int STOP_BITS    = 1
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] parallel_data_in,
  input  logic                 data_load,
  output logic                 ready,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 serial_data_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_e        state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic             par_q;
  logic             line_q;
  logic             shift_lsb;

  logic bit_end;
  logic last_data;
  logic last_stop;
  logic accept;
  logic shift;

  assign bit_end   = (clk_cnt == CNT_LAST);
  assign last_data = (bit_cnt == DATA_LAST);
  assign last_stop = (bit_cnt == STOP_LAST);
  assign accept    = data_load && (state == ST_IDLE);

  // Each time the line takes a data bit from the LSB, expose the next one.
  assign shift = bit_end &&
                 ((state == ST_PARITY) ||
                  ((state == ST_DATA) && !last_data));

  piso_reg u_piso (
    .sys_clk (sys_clk),
    .rst     (rst),
    .load    (accept),
    .shift   (shift),
    .d       (parallel_data_in),
    .lsb     (shift_lsb)
  );

  // Frame sequencer, bit timer and registered serial line.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          line_q  <= 1'b1;
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (data_load) begin
            state  <= ST_START;
            line_q <= 1'b0;
            par_q  <= odd_parity(parallel_data_in);
          end
        end
        ST_START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            state   <= ST_PARITY;
            line_q  <= par_q;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= ST_DATA;
            line_q  <= shift_lsb;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (last_data) begin
              bit_cnt <= '0;
              state   <= ST_STOP;
              line_q  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              line_q  <= shift_lsb;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          line_q <= 1'b1;
          if (bit_end) begin
            clk_cnt <= '0;
            if (last_stop) begin
              bit_cnt <= '0;
              state   <= ST_IDLE;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= ST_IDLE;
          line_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready           = (state == ST_IDLE);
  assign busy            = (state != ST_IDLE);
  assign tx_done         = (state == ST_STOP) && bit_end && last_stop;
  assign serial_data_out = line_q;

endmodule
